// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: parity modes, FSM states
// and the baud divisor table (50 MHz clock, 16 ticks per bit).
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DIV_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud
    localparam logic [DIV_W-1:0] BAUD_DIV [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326,
        14'd163,   14'd81,   14'd54,  14'd27
    };

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        return BAUD_DIV[sel];
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one tick every baud_div(select) clocks.
// restart reloads the down-counter so a new frame begins with a full bit.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [2:0] select,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= baud_div(select) - DIV_W'(1);
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with an inline TX FIFO, configurable frame format and
// selectable baud rate latched at the start of every frame.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for Tx_EN and queued data
// ST_START  | start bit (low)
// ST_DATA   | DATA_BITS data bits, LSB first
// ST_PARITY | even/odd parity bit (skipped when PARITY=0)
// ST_STOP   | STOP_BITS stop bits (high)
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic [2:0]                    baud_select,
    input  logic                          Tx_EN,
    input  logic                          Tx_WR,
    input  logic [DATA_BITS-1:0]          Tx_DATA,
    output logic                          Tx_FULL,
    output logic                          Tx_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   Tx_COUNT,
    output logic                          Tx_OVF,
    output logic                          Tx_BUSY,
    output logic                          TxD
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count_nxt;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    tx_state_t            state;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bit;
    logic [2:0]           bit_cnt;
    logic [3:0]           tick_cnt;
    logic [2:0]           sel_q;
    logic [2:0]           gen_sel;
    logic                 tick;
    logic                 bit_end;

    assign head    = mem[rd_ptr];
    assign pop     = (state == ST_IDLE) && Tx_EN && !Tx_EMPTY;
    assign push    = Tx_WR && (!Tx_FULL || pop);
    assign bit_end = tick && (tick_cnt == 4'd0);
    // the new rate must already drive the divider reload in the pop cycle
    assign gen_sel = pop ? baud_select : sel_q;

    uart_baud_gen u_baud_gen (
        .Clk     (Clk),
        .reset   (reset),
        .restart (pop),
        .select  (gen_sel),
        .tick    (tick)
    );

    always_comb begin
        count_nxt = Tx_COUNT;
        if (push && !pop) begin
            count_nxt = Tx_COUNT + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = Tx_COUNT - (AW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= Tx_DATA;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Tx_COUNT <= '0;
            Tx_EMPTY <= 1'b1;
            Tx_FULL  <= 1'b0;
            Tx_OVF   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (Tx_WR && !push) begin
                Tx_OVF <= 1'b1;
            end
            Tx_COUNT <= count_nxt;
            Tx_FULL  <= (count_nxt == DEPTH_CNT);
            Tx_EMPTY <= (count_nxt == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            sh       <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            sel_q    <= '0;
        end else begin
            if (state != ST_IDLE && tick) begin
                tick_cnt <= tick_cnt - 4'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_START;
                        Tx_BUSY  <= 1'b1;
                        TxD      <= 1'b0;
                        sh       <= head;
                        par_bit  <= (^head) ^ (PARITY == PAR_ODD);
                        sel_q    <= baud_select;
                        tick_cnt <= 4'd15;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        TxD     <= sh[0];
                        sh      <= sh >> 1;
                        bit_cnt <= 3'(DATA_BITS - 1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            TxD     <= sh[0];
                            sh      <= sh >> 1;
                            bit_cnt <= bit_cnt - 3'd1;
                        end else if (PARITY != PAR_NONE) begin
                            state <= ST_PARITY;
                            TxD   <= par_bit;
                        end else begin
                            state   <= ST_STOP;
                            TxD     <= 1'b1;
                            bit_cnt <= 3'(STOP_BITS - 1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        TxD     <= 1'b1;
                        bit_cnt <= 3'(STOP_BITS - 1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end else begin
                            state   <= ST_IDLE;
                            Tx_BUSY <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    TxD     <= 1'b1;
                    Tx_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning frame data width (legal 5..8).
REQ-002 SHALL have parameter PARITY, default 1, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop-bit count (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning TX buffer entries (power of two, >=2).
REQ-005 SHALL have port Clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port baud_select  input  3  baud rate index.
REQ-008 SHALL have port Tx_EN  input  1  allows new frames to start.
REQ-009 SHALL have port Tx_WR  input  1  one-cycle FIFO write strobe.
REQ-010 SHALL have port Tx_DATA  input  DATA_BITS  write data.
REQ-011 SHALL have port Tx_FULL  output  1  FIFO full.
REQ-012 SHALL have port Tx_EMPTY  output  1  FIFO empty.
REQ-013 SHALL have port Tx_COUNT  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 SHALL have port Tx_OVF  output  1  sticky overflow flag.
REQ-015 SHALL have port Tx_BUSY  output  1  frame in progress.
REQ-016 SHALL have port TxD  output  1  serial line, idle high.

Function
REQ-017 Baud tick divisors at 50 MHz Clk, 16 ticks per bit, SHALL be for baud_select 0..7: 10417, 2604, 651, 326, 163, 81, 54, 27 (300 to 115200 baud).
REQ-018 FIFO write SHALL occur on Tx_WR when not full, or when full with a pop in the same cycle; it is independent of Tx_EN.
REQ-019 Tx_WR while full without a same-cycle pop SHALL drop the data and set Tx_OVF, which then holds until reset.
REQ-020 Tx_COUNT, Tx_FULL and Tx_EMPTY SHALL be registered and SHALL update the cycle after a push or pop; simultaneous push and pop SHALL leave the count unchanged.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE->START SHALL occur when Tx_EN=1 and FIFO is not empty; the head entry is popped and baud_select is latched in that cycle.
REQ-023 TxD SHALL go low in the cycle after the pop; each bit SHALL last exactly 16 ticks.
REQ-024 The tick divider SHALL restart at frame start so the start bit is full length.
REQ-025 DATA SHALL shift out DATA_BITS bits LSB first.
REQ-026 DATA SHALL go to PARITY, or to STOP when PARITY=0.
REQ-027 The parity bit SHALL make the count of ones over data+parity even (PARITY=1) or odd (PARITY=2).
REQ-028 STOP SHALL drive 1 for STOP_BITS bit periods, then go to IDLE.
REQ-029 Back-to-back frames SHALL insert exactly one idle cycle between the last stop bit and the next start bit.
REQ-030 A baud_select change mid-frame SHALL have no effect until the next frame.
REQ-031 Tx_EN deasserted mid-frame SHALL let the current frame complete, and no further frame SHALL start.
REQ-032 Tx_BUSY SHALL be 1 exactly when state is not IDLE.

Reset
REQ-033 On reset: state IDLE, TxD=1, Tx_BUSY=0, FIFO pointers cleared, Tx_COUNT=0, Tx_EMPTY=1, Tx_FULL=0, Tx_OVF=0, divider cleared.
REQ-034 Reset mid-frame SHALL abort the frame, with TxD=1 from the next cycle; buffered data is discarded.
REQ-035 Tx_WR asserted during reset SHALL be ignored.

Structure
REQ-036 Package uart_pkg SHALL hold the parity-mode constants, the FSM state typedef and the 8-entry baud divisor table.
REQ-037 Sub-module uart_baud_gen SHALL hold the tick generator, with inputs Clk, reset, restart and select, and output tick.
REQ-038 FIFO storage and pointers SHALL be inline in uart_tx_buffered.

Verification
REQ-039 Defaults, baud_select=7, write 0xA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,0(parity),1; each bit 432 cycles; frame 4752 cycles.
REQ-040 Tx_EN=0, 17 writes with FIFO_DEPTH=16 -> Tx_COUNT=16, Tx_FULL=1, Tx_OVF=1, TxD stays 1; then Tx_EN=1 -> 16 frames in write order, Tx_OVF remains 1.
REQ-041 DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x7F -> 7 ones, parity 0, two stop bits, frame 11 bit periods.
REQ-042 Reset asserted during the DATA state -> next cycle TxD=1, Tx_BUSY=0, Tx_COUNT=0; no residual frame.
REQ-043 Tx_EN dropped mid-frame with 3 entries queued -> current frame completes, Tx_COUNT=2, TxD idle; baud_select changed mid-frame -> next frame uses the new rate.
